// File: rtl/c_table_rd_arbiter.sv
// Round-robin read arbiter and host loader in front of a shared C-table SRAM.
// Optional macro C_ARB_RSP_REG_EN adds an output register stage on the response (latency 2).
module c_table_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 18,
    parameter int WIDTHS     = 1920
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_err,
    output logic [WIDTHS-1:0]             rsp_data,
    input  logic                          ld_valid,
    input  logic [ADDR_WIDTH-1:0]         ld_addr,
    input  logic [WIDTHS-1:0]             ld_data,
    output logic                          ld_ready,
    input  logic                          ld_done,
    output logic                          sram_wEn,
    output logic                          sram_rEn,
    output logic [ADDR_WIDTH-1:0]         sram_wAddr,
    output logic [ADDR_WIDTH-1:0]         sram_rAddr,
    output logic [WIDTHS-1:0]             sram_wData,
    input  logic [WIDTHS-1:0]             sram_rData,
    output logic [15:0]                   rd_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [PTR_W-1:0]        rr_ptr_r;
    logic [PTR_W-1:0]        grant_idx_s;
    logic                    grant_any_s;
    logic [NUM_REQ-1:0]      grant_s;
    logic [ADDR_WIDTH-1:0]   grant_addr_s;
    logic                    addr_err_s;
    int                      lane_s;
    logic [NUM_REQ-1:0]      rsp_valid_r;
    logic                    rsp_err_r;
    logic [15:0]             rd_count_r;

    // Next-state: LOAD leaves on ld_done, RUN is only left through reset
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD: begin
                if (ld_done) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            RUN:     state_nxt_s = RUN;
            default: state_nxt_s = LOAD;
        endcase
    end

    // Round-robin search starting one past the last granted lane; host writes block grants
    always_comb begin
        lane_s      = 0;
        grant_any_s = 1'b0;
        grant_idx_s = rr_ptr_r;
        if (state_r == RUN && !ld_valid) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                lane_s = (int'(rr_ptr_r) + k) % NUM_REQ;
                if (!grant_any_s && req_valid[lane_s]) begin
                    grant_any_s = 1'b1;
                    grant_idx_s = PTR_W'(lane_s);
                end else begin
                    grant_idx_s = grant_idx_s;
                end
            end
        end else begin
            grant_any_s = 1'b0;
        end
    end

    assign grant_s      = grant_any_s ? (NUM_REQ'(1) << grant_idx_s) : '0;
    assign grant_addr_s = req_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
    assign addr_err_s   = ({1'b0, grant_addr_s} >= (ADDR_WIDTH+1)'(DEPTH));

    assign req_ready  = grant_s;
    assign ld_ready   = 1'b1;
    assign sram_wEn   = ld_valid;
    assign sram_wAddr = ld_addr;
    assign sram_wData = ld_data;
    assign sram_rEn   = grant_any_s && !addr_err_s;
    assign sram_rAddr = grant_addr_s;
    assign rd_count   = rd_count_r;

    // Control state: FSM, round-robin pointer and saturating grant counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= LOAD;
            rr_ptr_r   <= PTR_W'(NUM_REQ - 1);
            rd_count_r <= 16'h0000;
        end else begin
            state_r <= state_nxt_s;
            if (grant_any_s) begin
                rr_ptr_r <= grant_idx_s;
                if (rd_count_r != 16'hFFFF) begin
                    rd_count_r <= rd_count_r + 16'h0001;
                end else begin
                    rd_count_r <= rd_count_r;
                end
            end else begin
                rr_ptr_r   <= rr_ptr_r;
                rd_count_r <= rd_count_r;
            end
        end
    end

    // Response strobe aligned with the SRAM's registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_valid_r <= grant_s;
            rsp_err_r   <= grant_any_s && addr_err_s;
        end
    end

`ifdef C_ARB_RSP_REG_EN
    logic [NUM_REQ-1:0] rsp_valid_d2_r;
    logic               rsp_err_d2_r;
    logic [WIDTHS-1:0]  rsp_data_d2_r;

    // Extra output stage to ease timing on the wide data path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_d2_r <= '0;
            rsp_err_d2_r   <= 1'b0;
            rsp_data_d2_r  <= '0;
        end else begin
            rsp_valid_d2_r <= rsp_valid_r;
            rsp_err_d2_r   <= rsp_err_r;
            rsp_data_d2_r  <= sram_rData;
        end
    end

    assign rsp_valid = rsp_valid_d2_r;
    assign rsp_err   = rsp_err_d2_r;
    assign rsp_data  = rsp_data_d2_r;
`else
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_data  = sram_rData;
`endif

endmodule

// File: tb/tb_c_table_rd_arbiter.sv
// Scoreboard bench for c_table_rd_arbiter with an SRAM model and a table-level reference model.
module tb_c_table_rd_arbiter;

`ifdef C_ARB_RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    req_valid = '0;
    logic [19:0]   req_addr = '0;
    logic [3:0]    req_ready;
    logic [3:0]    rsp_valid;
    logic          rsp_err;
    logic [1919:0] rsp_data;
    logic          ld_valid = 1'b0;
    logic [4:0]    ld_addr = '0;
    logic [1919:0] ld_data = '0;
    logic          ld_ready;
    logic          ld_done = 1'b0;
    logic          sram_wEn, sram_rEn;
    logic [4:0]    sram_wAddr, sram_rAddr;
    logic [1919:0] sram_wData;
    logic [1919:0] sram_rData;
    logic [15:0]   rd_count;

    c_table_rd_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_done(ld_done),
        .sram_wEn(sram_wEn), .sram_rEn(sram_rEn),
        .sram_wAddr(sram_wAddr), .sram_rAddr(sram_rAddr),
        .sram_wData(sram_wData), .sram_rData(sram_rData),
        .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: registered read, separate write port
    logic [1919:0] mem [32];
    always @(posedge clk) begin
        if (sram_wEn) mem[sram_wAddr] <= sram_wData;
        if (sram_rEn) sram_rData <= mem[sram_rAddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]    lanes;
        logic          err;
        logic [1919:0] data;
        int            due;
    } exp_t;
    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: table contents, last granted lane, load/run phase, grant count
    logic [1919:0] ref_mem [32];
    bit  m_run;
    int  m_last;
    int  m_count;
    int  g_lane;

    task automatic chk(input string name, input logic [1919:0] act, input logic [1919:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act[127:0], exp[127:0]);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_last  = 3;
        m_count = 0;
        g_lane  = -1;
    endtask

    function automatic logic [1919:0] pattern(input int k);
        logic [1919:0] p;
        for (int i = 0; i < 60; i++) p[i*32 +: 32] = (32'(k) * 32'h9E3779B1) ^ 32'(i * 7 + 1);
        return p;
    endfunction

    function automatic logic [1919:0] rnd_data();
        logic [1919:0] p;
        for (int i = 0; i < 60; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    // Checks combinational outputs for the current cycle, then advances the model across the edge
    task automatic check_cycle();
        int          lane;
        logic [4:0]  a;
        bit          err;
        exp_t        e;
        lane = -1;
        if (rst_n && m_run && !ld_valid) begin
            for (int k = 1; k <= 4; k++) begin
                if (lane < 0 && req_valid[(m_last + k) % 4]) lane = (m_last + k) % 4;
            end
        end
        a   = (lane >= 0) ? req_addr[lane*5 +: 5] : 5'd0;
        err = (lane >= 0) && (a >= 5'd18);
        chk("req_ready", req_ready, (lane >= 0) ? (4'b0001 << lane) : 4'b0000);
        chk("sram_rEn", sram_rEn, (lane >= 0) && !err);
        if (lane >= 0 && !err) chk("sram_rAddr", sram_rAddr, a);
        chk("sram_wEn", sram_wEn, ld_valid);
        if (ld_valid) begin
            chk("sram_wAddr", sram_wAddr, ld_addr);
            chk("sram_wData", sram_wData, ld_data);
        end
        chk("ld_ready", ld_ready, 1'b1);
        chk("rd_count", rd_count, 16'(m_count));
        g_lane = lane;
        if (rst_n) begin
            if (lane >= 0) begin
                e.lanes = 4'b0001 << lane;
                e.err   = err;
                e.data  = ref_mem[a];
                e.due   = cyc + LAT;
                q.push_back(e);
                m_last  = lane;
                if (m_count < 65535) m_count++;
            end
            if (ld_valid) ref_mem[ld_addr] = ld_data;
            if (!m_run && ld_done) m_run = 1'b1;
        end
    endtask

    task automatic drive(input logic [3:0] rv, input logic [19:0] ra, input logic lv,
                         input logic [4:0] la, input logic [1919:0] ld, input logic dn);
        @(posedge clk);
        #1;
        req_valid = rv;
        req_addr  = ra;
        ld_valid  = lv;
        ld_addr   = la;
        ld_data   = ld;
        ld_done   = dn;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'b0000, 20'h0, 1'b0, 5'd0, '0, 1'b0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rsp_valid_in_reset", rsp_valid, 4'b0000);
            chk("rsp_err_in_reset", rsp_err, 1'b0);
        end else begin
            while (q.size() > 0 && q[0].due < cyc) begin
                e = q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_rsp at cycle %0d: got none expected lanes %b", cyc, e.lanes);
            end
            if (rsp_valid != 4'b0000) begin
                if (q.size() == 0 || q[0].due != cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp at cycle %0d: got %b expected none", cyc, rsp_valid);
                end else begin
                    e = q.pop_front();
                    chk("rsp_valid", rsp_valid, e.lanes);
                    chk("rsp_err", rsp_err, e.err);
                    if (!e.err) chk("rsp_data", rsp_data, e.data);
                end
            end
        end
    end

    logic [3:0]  cv;
    logic [19:0] ca;
    logic [1919:0] newpat;

    initial begin
        model_reset();
        // Reset: lanes requesting, nothing may be granted or enabled
        for (int i = 0; i < 3; i++) drive(4'b1111, 20'h0, 1'b0, 5'd0, '0, 1'b0);
        rst_n = 1'b1;

        // Load all entries while every lane requests; ld_done rides on the last write
        for (int k = 0; k < 18; k++) drive(4'b1111, 20'h0, 1'b1, 5'(k), pattern(k), k == 17);

        // All lanes held for 8 cycles: rotation through every lane
        for (int i = 0; i < 8; i++) drive(4'b1111, {5'd3, 5'd2, 5'd1, 5'd0}, 1'b0, 5'd0, '0, 1'b0);
        idle(2);
        chk("rd_count_after_8", rd_count, 16'd8);

        // Lane 0 reads address 5
        drive(4'b0001, {15'h0, 5'd5}, 1'b0, 5'd0, '0, 1'b0);
        idle(2);

        // Host write collides with lane 2 request; lane 2 reads the fresh data next cycle
        newpat = rnd_data();
        drive(4'b0100, {5'd0, 5'd7, 10'h0}, 1'b1, 5'd7, newpat, 1'b0);
        drive(4'b0100, {5'd0, 5'd7, 10'h0}, 1'b0, 5'd0, '0, 1'b0);
        idle(2);

        // Out-of-range address on lane 1
        drive(4'b0010, {10'h0, 5'd20, 5'd0}, 1'b0, 5'd0, '0, 1'b0);
        idle(2);

        // Random traffic with lanes holding requests until granted
        cv = '0;
        ca = '0;
        for (int c = 0; c < 300; c++) begin
            for (int l = 0; l < 4; l++) begin
                if (!(cv[l] && g_lane != l && ($urandom % 20) != 0)) begin
                    cv[l] = ($urandom % 3) != 0;
                    ca[l*5 +: 5] = 5'($urandom % 24);
                end
            end
            drive(cv, ca, ($urandom % 5) == 0, 5'($urandom % 18), rnd_data(), ($urandom % 16) == 0);
        end
        idle(3);

        // Reset the cycle after a grant: response dropped, back to LOAD, counter cleared
        drive(4'b1000, {5'd2, 15'h0}, 1'b0, 5'd0, '0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 4'b0000;
        q.delete();
        model_reset();
        @(negedge clk);
        check_cycle();
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b0, 5'd0, '0, 1'b0);
        drive(4'b0000, 20'h0, 1'b0, 5'd0, '0, 1'b1);
        drive(4'b0001, {15'h0, 5'd5}, 1'b0, 5'd0, '0, 1'b0);
        idle(4);

        chk("scoreboard_drained", 1920'(q.size()), 1920'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
